// File: rtl/rx_mod.sv
// UART receiver: 2-flop synchronizer, tick-driven START/DATA/STOP FSM,
// holding register with valid/acknowledge handshake, frame-error pulse
// and sticky overrun flag.
//
// Handshake: rx_vld is a level meaning "dout holds an unread byte". The
// consumer takes the byte by asserting rx_ack on any edge where rx_vld is 1;
// rx_vld (and overrun) drop on the following cycle. rx_ack while rx_vld is 0
// is ignored. A new byte landing on the same edge as rx_ack is kept valid.
`timescale 1ns/1ps
module rx_mod #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_vld,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FSM state; kept as a named enum so checkers can bind to it directly.
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [BW-1:0]          r_bit;
    logic [BW-1:0]          w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rs;
    logic                   w_stop_ok;
    logic                   w_stop_bad;

    assign w_rs = r_sync2;

    // Two-flop synchronizer for the asynchronous line; resets to idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // State register together with the counters and shift register it owns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic; everything holds unless this edge carries a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        if (s_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rs) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == MID_START) begin
                        w_cnt_nxt = '0;
                        w_bit_nxt = '0;
                        // A line that is high again mid start bit was noise.
                        w_state_nxt = w_rs ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_BIT) begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = {w_rs, r_shift[DATA_BITS-1:1]};
                        if (r_bit == LAST_BIT) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_BIT) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode: stop-bit verdict on the mid-stop tick, busy from state.
    always_comb begin
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        busy       = (r_state != S_IDLE);
        if (s_tick && (r_state == S_STOP) && (r_cnt == FULL_BIT)) begin
            w_stop_ok  = w_rs;
            w_stop_bad = !w_rs;
        end
    end

    // Holding register, handshake and error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout      <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_bad;
            if (w_stop_ok) begin
                dout   <= r_shift;
                rx_vld <= 1'b1;
                if (rx_vld && !rx_ack) begin
                    overrun <= 1'b1;
                end else if (rx_vld && rx_ack) begin
                    overrun <= 1'b0;
                end
            end else if (rx_vld && rx_ack) begin
                rx_vld  <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rx_mod.md
Name: rx_mod

Overview:
- UART receiver.
- Sits downstream of the serial transmitter: it consumes the txd line of a remote or looped-back transmitter and reconstructs bytes.
- Frame format matches the transmitter: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), no parity.
- Samples the line using an external oversampling tick and presents each received byte in a holding register with a valid/acknowledge handshake plus error flags.

Parameters:
- OVERSAMPLE, 16: tick pulses per bit period; must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame; dout width.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- s_tick  input  1  one-clk-wide pulse at OVERSAMPLE × baud rate.
- rxd  input  1  asynchronous serial line, idle high.
- rx_ack  input  1  consumer acknowledges dout; clears rx_vld and overrun.
- dout  output  DATA_BITS  last received byte (holding register).
- rx_vld  output  1  holding register full; level signal.
- frame_err  output  1  one-clk pulse: stop bit sampled as 0.
- overrun  output  1  sticky: a byte completed while rx_vld was 1.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst = 0 at posedge clk):
  - dout = 0; rx_vld, frame_err and overrun = 0; busy = 0.
  - FSM = IDLE; tick counter, bit counter and shift register = 0.
  - Both synchronizer flops = 1.
  - Reset mid-frame abandons the frame; nothing is written to dout.
- Synchronizer:
  - rxd passes through 2 flops; the FSM uses only the synced bit rs.
  - Input-to-rs latency is 2 clk.
- Tick counter:
  - log2(OVERSAMPLE) bits wide.
  - Advances only on clk edges where s_tick = 1; all FSM sampling decisions happen on tick edges.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with rs = 0, go to START, counter = 0. busy = 1 from the next cycle.
  - START: count ticks. On the tick where counter = OVERSAMPLE/2 - 1 (mid start bit):
    - rs = 0: go to DATA, counter = 0, bit counter = 0.
    - rs = 1: glitch; return to IDLE with no output activity.
  - DATA: count ticks. On the tick where counter = OVERSAMPLE - 1 (mid data bit):
    - shift rs in at the MSB of the shift register (right shift, so LSB-first arrival ends at bit 0);
    - counter = 0; bit counter increments.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where counter = OVERSAMPLE - 1 (mid stop bit):
    - rs = 1: dout ← shift register; rx_vld = 1 next cycle.
    - rs = 0: frame_err = 1 for exactly one clk; dout and rx_vld unchanged.
    - Either way, go to IDLE the same edge. A new start bit can be detected on the very next tick (back-to-back frames).
- Handshake:
  - rx_ack = 1 with rx_vld = 1: rx_vld and overrun clear next cycle.
  - rx_ack with rx_vld = 0: no effect.
- Overrun:
  - A good frame completes while rx_vld = 1 and rx_ack = 0: dout is overwritten with the new byte, rx_vld stays 1, overrun = 1 (sticky).
  - Completion and rx_ack on the same edge: new byte loaded, rx_vld stays 1, overrun cleared/not set.
- frame_err never sets overrun and never clears rx_vld.
- s_tick held 0: FSM frozen in its current state; counters hold.

Test Plan:
- Clean frame:
  - Stimulus: s_tick every 4 clk; serialize 0xA5 LSB first, 16 ticks per bit.
  - Required: rx_vld rises 1 clk after the mid-stop tick; dout = 0xA5; frame_err = 0; busy = 0 after the frame.
  - Then pulse rx_ack: rx_vld = 0 next cycle.
- Start-bit glitch:
  - Stimulus: rxd low for 4 ticks, then high.
  - Required: FSM returns to IDLE; rx_vld, frame_err and dout unchanged; busy pulses only for the glitch duration.
- Framing error:
  - Stimulus: send 0x3C with stop bit = 0.
  - Required: frame_err high for exactly 1 clk; rx_vld stays 0; dout keeps its previous value.
- Overrun:
  - Stimulus: send 0x11 then 0x22 back-to-back, no rx_ack.
  - Required: dout = 0x22; rx_vld = 1; overrun = 1.
  - Then pulse rx_ack: rx_vld = 0 and overrun = 0.
- Simultaneous ack:
  - Stimulus: with rx_vld = 1 holding 0x55, assert rx_ack on the completion edge of 0x66.
  - Required: dout = 0x66; rx_vld = 1; overrun = 0.
- Reset mid-frame:
  - Stimulus: drive rst = 0 for 1 clk during data bit 3 of 0xF0.
  - Required: all outputs 0; no byte delivered.
  - Then send 0x81: received correctly.
